// File: rtl/hazard_ctrl_sb.sv
// Hazard controller for the MINI-RISC pipeline: M/W operand forwarding, load-use bubbles,
// a busy scoreboard for multi-cycle ops, and flush stretching after redirects.
module hazard_ctrl_sb #(
  parameter int REG_AW       = 3,
  parameter int MC_LAT       = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int ZERO_REG_HW  = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_AW-1:0]         rs1_D,
  input  logic [REG_AW-1:0]         rs2_D,
  input  logic [REG_AW-1:0]         rd_D,
  input  logic                      reg_write_D,
  input  logic                      mc_op_D,
  input  logic [REG_AW-1:0]         rs1_E,
  input  logic [REG_AW-1:0]         rs2_E,
  input  logic [REG_AW-1:0]         rd_E,
  input  logic                      reg_write_E,
  input  logic                      mem_read_E,
  input  logic                      mc_start_E,
  input  logic [REG_AW-1:0]         rd_M,
  input  logic                      reg_write_M,
  input  logic [REG_AW-1:0]         rd_W,
  input  logic                      reg_write_W,
  input  logic                      redirect,
  output logic                      stall_F,
  output logic                      stall_D,
  output logic                      flush_F,
  output logic                      flush_D,
  output logic [1:0]                forward_A,
  output logic [1:0]                forward_B,
  output logic [(1<<REG_AW)-1:0]    sb_busy,
  output logic                      mc_busy,
  output logic                      mc_done
);

  localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 1);
  localparam logic [1:0] FL_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [3:0]        mc_cnt;
  logic [REG_AW-1:0] mc_rd;
  logic [1:0]        fl_cnt;
  logic              load_use;
  logic              sb_raw;
  logic              mc_struct;
  logic              hold;
  logic              flush_act;
  logic              mc_accept;

  function automatic logic reg_match(input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src,
                                     input logic              wr);
    return wr && (dst == src) && !((ZERO_REG_HW != 0) && (dst == '0));
  endfunction

  always_comb begin
    forward_A = 2'b00;
    if (reg_match(rd_M, rs1_E, reg_write_M))      forward_A = 2'b01;
    else if (reg_match(rd_W, rs1_E, reg_write_W)) forward_A = 2'b10;
  end

  always_comb begin
    forward_B = 2'b00;
    if (reg_match(rd_M, rs2_E, reg_write_M))      forward_B = 2'b01;
    else if (reg_match(rd_W, rs2_E, reg_write_W)) forward_B = 2'b10;
  end

  assign mc_done   = mc_busy && (mc_cnt == 4'd1);
  assign load_use  = mem_read_E && (reg_match(rd_E, rs1_D, reg_write_E) ||
                                    reg_match(rd_E, rs2_D, reg_write_E));
  // Last term is the WAW check: a new writer must not land before the in-flight result.
  assign sb_raw    = sb_busy[rs1_D] | sb_busy[rs2_D] | (reg_write_D & sb_busy[rd_D]);
  assign mc_struct = mc_op_D & mc_busy & ~mc_done;
  assign hold      = load_use | sb_raw | mc_struct;

  // A pending flush wins over any hold so the fetch PC can take the redirect target.
  assign flush_act = redirect | (fl_cnt != 2'd0);
  assign flush_F   = flush_act;
  assign flush_D   = flush_act | hold;
  assign stall_F   = hold & ~flush_act;
  assign stall_D   = hold & ~flush_act;

  assign mc_accept = mc_start_E & ~mc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fl_cnt <= 2'd0;
    end else if (redirect) begin
      fl_cnt <= FL_LOAD;
    end else if (fl_cnt != 2'd0) begin
      fl_cnt <= fl_cnt - 2'd1;
    end
  end

  // Redirects deliberately leave the scoreboard alone: the op already committed in E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_busy <= '0;
      mc_busy <= 1'b0;
      mc_cnt  <= 4'd0;
      mc_rd   <= '0;
    end else if (mc_done) begin
      sb_busy[mc_rd] <= 1'b0;
      mc_busy        <= 1'b0;
      mc_cnt         <= 4'd0;
    end else if (mc_busy) begin
      mc_cnt <= mc_cnt - 4'd1;
    end else if (mc_accept) begin
      mc_busy <= 1'b1;
      mc_cnt  <= MC_LOAD;
      mc_rd   <= rd_E;
      if (!((ZERO_REG_HW != 0) && (rd_E == '0))) sb_busy[rd_E] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// Self-checking bench for hazard_ctrl_sb: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a cycle-indexed behavioural model.
module tb_hazard_ctrl_sb;
  localparam int AW  = 3;
  localparam int LAT = 4;
  localparam int FC  = 3;
  localparam int ZR  = 1;
  localparam int NR  = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] rs1_D, rs2_D, rd_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic reg_write_D, mc_op_D, reg_write_E, mem_read_E, mc_start_E;
  logic reg_write_M, reg_write_W, redirect;
  logic stall_F, stall_D, flush_F, flush_D, mc_busy, mc_done;
  logic [1:0] forward_A, forward_B;
  logic [NR-1:0] sb_busy;

  int errors = 0;
  int checks = 0;

  // Behavioural model: busy set, one in-flight op with an absolute done cycle, flush end cycle.
  bit m_busy [NR];
  bit m_inflight;
  int m_done_at;
  int m_rd;
  int cyc;
  int flush_last;

  hazard_ctrl_sb #(.REG_AW(AW), .MC_LAT(LAT), .FLUSH_CYCLES(FC), .ZERO_REG_HW(ZR)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .reg_write_D(reg_write_D), .mc_op_D(mc_op_D),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .reg_write_E(reg_write_E),
    .mem_read_E(mem_read_E), .mc_start_E(mc_start_E),
    .rd_M(rd_M), .reg_write_M(reg_write_M), .rd_W(rd_W), .reg_write_W(reg_write_W),
    .redirect(redirect),
    .stall_F(stall_F), .stall_D(stall_D), .flush_F(flush_F), .flush_D(flush_D),
    .forward_A(forward_A), .forward_B(forward_B), .sb_busy(sb_busy),
    .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  function automatic bit mm(input int dst, input int src, input bit wr);
    return wr && (dst == src) && !(ZR != 0 && dst == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 0;
    m_inflight = 0;
    m_done_at  = 0;
    m_rd       = 0;
    flush_last = -1;
  endtask

  initial begin
    model_reset();
    cyc = 0;
  end

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (m_inflight && cyc == m_done_at) begin
        m_inflight = 0;
        m_busy[m_rd] = 0;
      end else if (!m_inflight && mc_start_E) begin
        m_inflight = 1;
        m_done_at  = cyc + LAT - 1;
        m_rd       = int'(rd_E);
        if (!(ZR != 0 && rd_E == 0)) m_busy[rd_E] = 1;
      end
      if (redirect) flush_last = cyc + FC - 1;
      cyc++;
    end
  end

  always @(negedge clk) begin : compare
    logic [1:0] efa, efb;
    logic [NR-1:0] esb;
    bit lu, raw, mcs, hold, fl, edone;
    efa = mm(int'(rd_M), int'(rs1_E), reg_write_M) ? 2'b01 :
          mm(int'(rd_W), int'(rs1_E), reg_write_W) ? 2'b10 : 2'b00;
    efb = mm(int'(rd_M), int'(rs2_E), reg_write_M) ? 2'b01 :
          mm(int'(rd_W), int'(rs2_E), reg_write_W) ? 2'b10 : 2'b00;
    for (int i = 0; i < NR; i++) esb[i] = m_busy[i];
    edone = m_inflight && (cyc == m_done_at);
    lu   = mem_read_E && (mm(int'(rd_E), int'(rs1_D), reg_write_E) ||
                          mm(int'(rd_E), int'(rs2_D), reg_write_E));
    raw  = m_busy[rs1_D] || m_busy[rs2_D] || (reg_write_D && m_busy[rd_D]);
    mcs  = mc_op_D && m_inflight && !edone;
    hold = lu || raw || mcs;
    fl   = redirect || (cyc <= flush_last);
    cmp("forward_A", 32'(forward_A), 32'(efa));
    cmp("forward_B", 32'(forward_B), 32'(efb));
    cmp("sb_busy",   32'(sb_busy),   32'(esb));
    cmp("mc_busy",   32'(mc_busy),   32'(m_inflight));
    cmp("mc_done",   32'(mc_done),   32'(edone));
    cmp("flush_F",   32'(flush_F),   32'(fl));
    cmp("flush_D",   32'(flush_D),   32'(fl || hold));
    cmp("stall_F",   32'(stall_F),   32'(hold && !fl));
    cmp("stall_D",   32'(stall_D),   32'(hold && !fl));
    checks++;
    if (mc_start_E && mc_busy) begin
      errors++;
      $display("FAIL mc_start_while_busy: mc_start_E=1 mc_busy=1 required not both (cycle %0d)", cyc);
    end
  end

  task automatic clr();
    rs1_D = '0; rs2_D = '0; rd_D = '0; reg_write_D = 0; mc_op_D = 0;
    rs1_E = '0; rs2_E = '0; rd_E = '0; reg_write_E = 0; mem_read_E = 0; mc_start_E = 0;
    rd_M = '0; reg_write_M = 0; rd_W = '0; reg_write_W = 0; redirect = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #2;
    cmp("rst_sb_busy", 32'(sb_busy), 0);
    cmp("rst_mc_busy", 32'(mc_busy), 0);
    cmp("rst_mc_done", 32'(mc_done), 0);
    cmp("rst_stall_F", 32'(stall_F), 0);
    cmp("rst_flush_F", 32'(flush_F), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Forwarding priority
    step();
    reg_write_M = 1; reg_write_W = 1; rd_M = 3; rd_W = 3; rs1_E = 3; rs2_E = 5;
    #1;
    cmp("fwd_A_M", 32'(forward_A), 1);
    cmp("fwd_B_rf", 32'(forward_B), 0);
    reg_write_M = 0;
    #1;
    cmp("fwd_A_W", 32'(forward_A), 2);

    // Load-use
    step(); clr();
    rs2_D = 2; mem_read_E = 1; reg_write_E = 1; rd_E = 2;
    #1;
    cmp("lu_stall_F", 32'(stall_F), 1);
    cmp("lu_stall_D", 32'(stall_D), 1);
    cmp("lu_flush_D", 32'(flush_D), 1);
    cmp("lu_flush_F", 32'(flush_F), 0);
    step();
    mem_read_E = 0; reg_write_E = 0;
    #1;
    cmp("lu_one_cycle", 32'(stall_F), 0);
    rd_E = 4; mem_read_E = 1; reg_write_E = 1;
    #1;
    cmp("lu_other_rd", 32'(stall_F), 0);

    // Multi-cycle RAW / structural / WAW
    step(); clr();
    mc_start_E = 1; rd_E = 6; reg_write_E = 1;
    #1;
    cmp("mc_c0_busy", 32'(mc_busy), 0);
    step(); clr();
    rs1_D = 6;
    #1;
    cmp("mc_c1_sb", 32'(sb_busy), 32'h40);
    cmp("mc_c1_busy", 32'(mc_busy), 1);
    cmp("mc_c1_raw_stall", 32'(stall_F), 1);
    cmp("mc_c1_done", 32'(mc_done), 0);
    step();
    rs1_D = 0; mc_op_D = 1;
    #1;
    cmp("mc_c2_struct", 32'(stall_D), 1);
    cmp("mc_c2_done", 32'(mc_done), 0);
    step();
    mc_op_D = 0; reg_write_D = 1; rd_D = 6;
    #1;
    cmp("mc_c3_done", 32'(mc_done), 1);
    cmp("mc_c3_waw", 32'(stall_F), 1);
    step(); clr();
    rs1_D = 6;
    #1;
    cmp("mc_c4_sb", 32'(sb_busy), 0);
    cmp("mc_c4_busy", 32'(mc_busy), 0);
    cmp("mc_c4_release", 32'(stall_F), 0);

    // Register 0 never enters the scoreboard
    step(); clr();
    mc_start_E = 1; rd_E = 0; reg_write_E = 1;
    step(); clr();
    #1;
    cmp("zr_sb", 32'(sb_busy), 0);
    cmp("zr_busy", 32'(mc_busy), 1);
    repeat (3) step();
    cmp("zr_retired", 32'(mc_busy), 0);

    // Flush stretch, single redirect
    clr();
    redirect = 1;
    #1 cmp("fl1_c0", 32'(flush_F), 1);
    step(); redirect = 0;
    #1 cmp("fl1_c1", 32'(flush_F), 1);
    step();
    #1 cmp("fl1_c2", 32'(flush_F), 1);
    step();
    #1 cmp("fl1_c3", 32'(flush_F), 0);

    // Flush stretch, second redirect plus load-use
    redirect = 1;
    step(); redirect = 1;
    #1 cmp("fl2_c1", 32'(flush_F), 1);
    step(); redirect = 0;
    mem_read_E = 1; reg_write_E = 1; rd_E = 2; rs2_D = 2;
    #1;
    cmp("fl2_c2_flush", 32'(flush_F), 1);
    cmp("fl2_c2_stallF", 32'(stall_F), 0);
    cmp("fl2_c2_stallD", 32'(stall_D), 0);
    cmp("fl2_c2_flushD", 32'(flush_D), 1);
    step(); clr();
    #1 cmp("fl2_c3", 32'(flush_F), 1);
    step();
    #1 cmp("fl2_c4", 32'(flush_F), 0);

    // Asynchronous reset with an op in flight
    clr();
    mc_start_E = 1; rd_E = 5; reg_write_E = 1;
    step(); clr();
    step();
    rs1_D = 5;
    #1 cmp("rst_mid_pre", 32'(stall_F), 1);
    #1;
    clr();
    rst_n = 1'b0;
    model_reset();
    #1;
    cmp("rst_mid_sb", 32'(sb_busy), 0);
    cmp("rst_mid_busy", 32'(mc_busy), 0);
    cmp("rst_mid_done", 32'(mc_done), 0);
    cmp("rst_mid_stall", 32'(stall_F), 0);
    cmp("rst_mid_flush", 32'(flush_F), 0);
    step();
    #2 rst_n = 1'b1;
    repeat (6) begin
      step();
      cmp("rst_no_done", 32'(mc_done), 0);
    end

    // Randomized traffic
    repeat (3000) begin
      step();
      rs1_D = AW'($urandom); rs2_D = AW'($urandom); rd_D = AW'($urandom);
      reg_write_D = ($urandom % 2) == 0;
      mc_op_D     = ($urandom % 4) == 0;
      rs1_E = AW'($urandom); rs2_E = AW'($urandom); rd_E = AW'($urandom);
      reg_write_E = ($urandom % 3) != 0;
      mem_read_E  = ($urandom % 3) == 0;
      mc_start_E  = !m_inflight && (($urandom % 5) == 0);
      rd_M = AW'($urandom); reg_write_M = ($urandom % 2) == 0;
      rd_W = AW'($urandom); reg_write_W = ($urandom % 2) == 0;
      redirect = ($urandom % 8) == 0;
    end
    step();
    clr();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
